dense_accum_buffer: RTL and testbench
=====================================

// Module: dense_accum_buffer
// PURPOSE
//  Parametrised successor to the single-vector dense output latch. Captures the
//  N_CH-wide PE-array output vector into a DEPTH-slot ring. Partial dense tiles can
//  be summed in place with signed saturating accumulation. Drains each committed
//  slot serially, one channel per beat, onto the output bus over a valid/ready handshake.
//  Sits between the PE array outputs and the output bus feeding the output buffer/ memory.
// PARAMETERS
//  N_CH   16  channels per vector (one per PE)
//  WID    16  signed two's-complement data width per channel
//  DEPTH  4   number of vector slots (>=2, power of two)
// PORTS
//  clk         in   1            clock; all logic on posedge
//  rst         in   1            synchronous active-high reset
//  latch_valid in   1            data_in presented for capture this cycle
//  latch_ready out  1            slot available (count<DEPTH); capture occurs on valid&ready
//  latch_accum in   1            1: slot += data_in (saturating); 0: slot = data_in
//  latch_last  in   1            final tile of this vector; commits the open slot on accept
//  data_in     in   N_CH*WID     PE outputs, channel c at [c*WID +: WID]
//  out_valid   out  1            out_data holds a valid beat
//  out_ready   in   1            consumer accepts the beat when out_valid&out_ready
//  out_data    out  WID          current channel of the oldest committed slot
//  out_ch      out  $clog2(N_CH) channel index of out_data
//  out_last    out  1            high with the beat for channel N_CH-1
//  count       out  $clog2(DEPTH)+1  committed, undrained slots
//  sat_flag    out  1            sticky: any accumulation saturated
//  ovf_flag    out  1            sticky: latch_valid while latch_ready=0 (data dropped)
//  clr_flags   in   1            clears sat_flag/ovf_flag next edge
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0, count=0, ch_idx=0, FSM=IDLE, out_valid=0, out_data=0,
//   out_ch=0, out_last=0, sat_flag=0, ovf_flag=0, latch_ready=1. Slot contents are
//   don't-care; a rst mid-drain or mid-accumulation discards all data and the open slot.
//  Write side: on accept (edge E), slot[wr_ptr] = latch_accum ? sat(slot[wr_ptr]+data_in)
//   : data_in, per channel independently. If latch_last, wr_ptr++ (mod DEPTH) and
//   count++ at E. Without latch_last the slot stays open for further tiles.
//  sat(): compute the WID+1-bit signed sum. Clamp to +2^(WID-1)-1 or -2^(WID-1) on overflow.
//   Any clamped channel sets sat_flag at E.
//  latch_ready = (count != DEPTH); combinational from registered count.
//  latch_valid & !latch_ready: no write, pointers unchanged, ovf_flag set.
//  Drain FSM: IDLE -> DRAIN when count>0 (transition at edge after count becomes
//   nonzero; commit at E gives out_valid high from E+1). In DRAIN: out_valid=1,
//   out_data=slot[rd_ptr][ch_idx], out_ch=ch_idx, out_last=(ch_idx==N_CH-1).
//   Each accepted beat: ch_idx++. An accepted last beat sets ch_idx=0, rd_ptr++ and
//   count--. The FSM stays in DRAIN if count-1>0, else returns to IDLE. out_valid
//   never drops while holding a beat. out_data/out_ch are stable while !out_ready.
//  Simultaneous commit and last-beat retire: count unchanged. Writing slot[wr_ptr]
//   while count==DEPTH is impossible (latch_ready=0). The open slot never aliases the draining
//   slot because wr_ptr != rd_ptr whenever count < DEPTH and count > 0.
//  Wrap-around: pointers are modulo DEPTH. count saturates at DEPTH by construction.
//  clr_flags concurrent with a new set event: set wins.
//  Throughput: 1 beat/cycle drain; 1 vector/cycle capture; no bubbles between slots.
// TESTING  (N_CH=4, WID=8, DEPTH=2)
//  Capture {4,3,2,1} (ch3..ch0) with accum=0, last=1 -> out beats 1,2,3,4 over 4 cycles
//   with out_ready=1. out_last on the 4th beat; count 1->0.
//  Tile 1 {10,10,10,10} accum=0 last=0, then tile 2 {5,-20,0,1} accum=1 last=1 ->
//   drain ch0..3 = 11,10,-10,15, sat_flag=0.
//  Accumulate 100+100 and -100+-100 -> 127 and -128, sat_flag=1. Then clr_flags -> sat_flag=0.
//  Commit 2 vectors with out_ready=0 -> count=2, latch_ready=0. A 3rd latch_valid ->
//   ovf_flag=1, the drained data are only the first 2 vectors.
//  Hold out_ready=0 for 5 cycles mid-vector -> out_data/out_ch constant. Resume ->
//   no beat lost or duplicated. Commit on the same edge as the last beat -> count stays 1.
//  Assert rst during DRAIN at ch_idx=2 -> next cycle out_valid=0, count=0, flags=0.
//   A fresh capture then drains correctly from slot 0.

Source files
------------

// File: rtl/dense_accum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dense_accum_buffer
// Description : DEPTH-slot ring of N_CH-wide vectors captured from the PE
//               array. Each slot may be built from several tiles using signed
//               saturating accumulation. Committed slots drain one channel per
//               beat over a valid/ready output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_accum_buffer #(
    parameter int N_CH  = 16,
    parameter int WID   = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      latch_valid,
    output logic                      latch_ready,
    input  logic                      latch_accum,
    input  logic                      latch_last,
    input  logic [N_CH*WID-1:0]       data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WID-1:0]            out_data,
    output logic [$clog2(N_CH)-1:0]   out_ch,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      sat_flag,
    output logic                      ovf_flag,
    input  logic                      clr_flags
);

    localparam int CHW = $clog2(N_CH);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [CHW-1:0] c_last_ch = CHW'(N_CH - 1);
    localparam logic [CW-1:0]  c_depth   = CW'(DEPTH);
    localparam logic [WID-1:0] c_pos_max = {1'b0, {(WID-1){1'b1}}};
    localparam logic [WID-1:0] c_neg_min = {1'b1, {(WID-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Slot storage; contents are deliberately not reset.
    logic [WID-1:0]   r_mem [DEPTH][N_CH];

    state_t           r_state;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CHW-1:0]   r_ch_idx;
    logic             r_out_valid;
    logic [WID-1:0]   r_out_data;
    logic             r_out_last;
    logic             r_sat_flag;
    logic             r_ovf_flag;

    logic             w_accept;
    logic             w_commit;
    logic             w_beat;
    logic             w_retire;
    logic [CW-1:0]    w_count_next;
    logic [PW-1:0]    w_rd_next;
    logic [CHW-1:0]   w_ch_next;
    logic [WID-1:0]   w_next_first;
    logic [N_CH-1:0]  w_clamp;
    logic [WID-1:0]   w_wr_ch [N_CH];

    assign latch_ready  = (r_count != c_depth);
    assign w_accept     = latch_valid & latch_ready;
    assign w_commit     = w_accept & latch_last;
    assign w_beat       = (r_state == ST_DRAIN) & r_out_valid & out_ready;
    assign w_retire     = w_beat & r_out_last;
    assign w_count_next = r_count + CW'(w_commit) - CW'(w_retire);
    assign w_rd_next    = r_rd_ptr + PW'(1);
    assign w_ch_next    = r_ch_idx + CHW'(1);

    // The slot after the retiring one may be committed on this very edge
    // (count was 1); forward the incoming vector so no bubble is needed.
    assign w_next_first = (w_accept && (r_wr_ptr == w_rd_next)) ? w_wr_ch[0]
                                                                : r_mem[w_rd_next][0];

    // Per-channel overwrite or saturating accumulate into the open slot.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [WID-1:0] w_old;
        logic [WID-1:0] w_new;
        logic [WID:0]   w_sum;
        logic           w_ovf;

        assign w_old      = r_mem[r_wr_ptr][c];
        assign w_new      = data_in[c*WID +: WID];
        assign w_sum      = {w_old[WID-1], w_old} + {w_new[WID-1], w_new};
        assign w_ovf      = w_sum[WID] ^ w_sum[WID-1];
        assign w_clamp[c] = latch_accum & w_ovf;
        assign w_wr_ch[c] = !latch_accum ? w_new :
                            w_ovf        ? (w_sum[WID] ? c_neg_min : c_pos_max) :
                                           w_sum[WID-1:0];
    end

    // Write the open slot on every accepted tile.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int c = 0; c < N_CH; c++) begin
                r_mem[r_wr_ptr][c] <= w_wr_ch[c];
            end
        end
    end

    // Pointers, occupancy, sticky flags and the drain state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ch_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_ovf_flag  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_count <= w_count_next;

            // A new set event takes priority over a concurrent clear.
            if (w_accept && (|w_clamp)) begin
                r_sat_flag <= 1'b1;
            end else if (clr_flags) begin
                r_sat_flag <= 1'b0;
            end

            if (latch_valid && !latch_ready) begin
                r_ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                r_ovf_flag <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= ST_DRAIN;
                        r_out_valid <= 1'b1;
                        r_ch_idx    <= '0;
                        r_out_data  <= r_mem[r_rd_ptr][0];
                        r_out_last  <= (c_last_ch == '0);
                    end
                end
                ST_DRAIN: begin
                    if (w_beat) begin
                        if (r_out_last) begin
                            r_rd_ptr <= w_rd_next;
                            r_ch_idx <= '0;
                            if (w_count_next != '0) begin
                                r_out_data <= w_next_first;
                                r_out_last <= (c_last_ch == '0);
                            end else begin
                                r_state     <= ST_IDLE;
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                            end
                        end else begin
                            r_ch_idx   <= w_ch_next;
                            r_out_data <= r_mem[r_rd_ptr][w_ch_next];
                            r_out_last <= (w_ch_next == c_last_ch);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_ch_idx;
    assign out_last  = r_out_last;
    assign count     = r_count;
    assign sat_flag  = r_sat_flag;
    assign ovf_flag  = r_ovf_flag;

endmodule
`default_nettype wire

// File: tb/tb_dense_accum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_accum_buffer
// Description : Directed bench for dense_accum_buffer (N_CH=4, WID=8,
//               DEPTH=2) with a beat scoreboard fed at capture time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_accum_buffer;

    localparam int N_CH  = 4;
    localparam int WID   = 8;
    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   latch_valid;
    logic                   latch_ready;
    logic                   latch_accum;
    logic                   latch_last;
    logic [N_CH*WID-1:0]    data_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [WID-1:0]         out_data;
    logic [1:0]             out_ch;
    logic                   out_last;
    logic [1:0]             count;
    logic                   sat_flag;
    logic                   ovf_flag;
    logic                   clr_flags;

    typedef struct packed {
        logic [WID-1:0] data;
        logic [1:0]     ch;
        logic           last;
    } beat_t;

    beat_t  sb [$];
    beat_t  mon_exp;
    int     tests = 0;
    int     fails = 0;
    int     m_acc [N_CH];
    bit     m_sat = 1'b0;

    dense_accum_buffer #(
        .N_CH  (N_CH),
        .WID   (WID),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .latch_valid (latch_valid),
        .latch_ready (latch_ready),
        .latch_accum (latch_accum),
        .latch_last  (latch_last),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .count       (count),
        .sat_flag    (sat_flag),
        .ovf_flag    (ovf_flag),
        .clr_flags   (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every accepted output beat against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("beat_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                check("beat_data", {24'd0, out_data}, {24'd0, mon_exp.data});
                check("beat_ch",   {30'd0, out_ch},   {30'd0, mon_exp.ch});
                check("beat_last", {31'd0, out_last}, {31'd0, mon_exp.last});
            end
        end
    end

    // Present one tile for one cycle and update the reference slot model.
    task automatic cap(input int d0, input int d1, input int d2, input int d3,
                       input bit acc, input bit last);
        int    d [N_CH];
        int    s;
        beat_t b;
        d = '{d0, d1, d2, d3};
        for (int c = 0; c < N_CH; c++) begin
            data_in[c*WID +: WID] = WID'(d[c]);
            s = acc ? (m_acc[c] + d[c]) : d[c];
            if (s > 127)  begin s = 127;  m_sat = 1'b1; end
            if (s < -128) begin s = -128; m_sat = 1'b1; end
            m_acc[c] = s;
        end
        if (last) begin
            for (int c = 0; c < N_CH; c++) begin
                b.data = WID'(m_acc[c]);
                b.ch   = 2'(c);
                b.last = (c == N_CH - 1);
                sb.push_back(b);
            end
        end
        latch_valid = 1'b1;
        latch_accum = acc;
        latch_last  = last;
        @(posedge clk);
        #1;
        latch_valid = 1'b0;
        latch_accum = 1'b0;
        latch_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && count == 2'd0) done = 1'b1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_ch(input string tag, input logic [1:0] target);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_ch == target) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WID-1:0] held_data;
        logic [1:0]     held_ch;
        bit             hit;

        rst = 1'b1; latch_valid = 1'b0; latch_accum = 1'b0; latch_last = 1'b0;
        data_in = '0; out_ready = 1'b1; clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid",   {31'd0, out_valid},   32'd0);
        check("rst_out_data",    {24'd0, out_data},    32'd0);
        check("rst_out_ch",      {30'd0, out_ch},      32'd0);
        check("rst_out_last",    {31'd0, out_last},    32'd0);
        check("rst_count",       {30'd0, count},       32'd0);
        check("rst_sat",         {31'd0, sat_flag},    32'd0);
        check("rst_ovf",         {31'd0, ovf_flag},    32'd0);
        check("rst_latch_ready", {31'd0, latch_ready}, 32'd1);

        // Simple capture and drain.
        @(posedge clk); #1;
        cap(1, 2, 3, 4, 1'b0, 1'b1);
        check("commit_count",     {30'd0, count},     32'd1);
        check("commit_out_valid", {31'd0, out_valid}, 32'd0);
        wait_drain("drain_simple");

        // Two-tile accumulation without saturation.
        cap(10, 10, 10, 10, 1'b0, 1'b0);
        cap(1, 0, -20, 5, 1'b1, 1'b1);
        check("accum_sat", {31'd0, sat_flag}, {31'd0, m_sat});
        wait_drain("drain_accum");

        // Saturating accumulation, then clear.
        cap(100, -100, 0, 0, 1'b0, 1'b0);
        cap(100, -100, 0, 0, 1'b1, 1'b1);
        check("sat_set", {31'd0, sat_flag}, 32'd1);
        wait_drain("drain_sat");
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        m_sat = 1'b0;
        check("sat_clear", {31'd0, sat_flag}, {31'd0, m_sat});
        check("ovf_clear", {31'd0, ovf_flag}, 32'd0);

        // Fill both slots while stalled, then overrun.
        out_ready = 1'b0;
        cap(11, 12, 13, 14, 1'b0, 1'b1);
        cap(21, 22, 23, 24, 1'b0, 1'b1);
        check("full_count",       {30'd0, count},       32'd2);
        check("full_latch_ready", {31'd0, latch_ready}, 32'd0);
        data_in = {8'd99, 8'd99, 8'd99, 8'd99};
        latch_valid = 1'b1; latch_last = 1'b1;
        @(posedge clk); #1;
        latch_valid = 1'b0; latch_last = 1'b0;
        check("ovf_set",     {31'd0, ovf_flag}, 32'd1);
        check("ovf_count",   {30'd0, count},    32'd2);
        out_ready = 1'b1;
        wait_drain("drain_full");

        // Stall mid-vector, resume, then commit on the retiring edge.
        cap(-1, -2, -3, -4, 1'b0, 1'b1);
        wait_ch("find_ch1", 2'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        held_data = out_data;
        held_ch   = out_ch;
        check("stall_ch", {30'd0, held_ch}, 32'd2);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data",  {24'd0, out_data},  {24'd0, held_data});
            check("stall_chan",  {30'd0, out_ch},    {30'd0, held_ch});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_ch("find_ch3", 2'd3);
        cap(31, -32, 33, -34, 1'b0, 1'b1);
        check("same_edge_count", {30'd0, count}, 32'd1);
        wait_drain("drain_same_edge");

        // Reset during drain at channel 2.
        cap(41, 42, 43, 44, 1'b0, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_ch == 2'd2) hit = 1'b1;
        end
        check("find_rst_point", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_sat = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count",     {30'd0, count},     32'd0);
        check("mid_rst_sat",       {31'd0, sat_flag},  32'd0);
        check("mid_rst_ovf",       {31'd0, ovf_flag},  32'd0);

        // Fresh vector after reset.
        cap(51, -52, 53, 127, 1'b0, 1'b1);
        wait_drain("drain_after_rst");
        repeat (5) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
